// File: rtl/hc595_chain_driver.sv
// Serialiser for a daisy chain of NUM_CHIPS 74HC595s: takes a parallel frame over
// valid/ready, shifts it out on SH_CP/DS at clk/(2*DIV), then pulses ST_CP.
`timescale 1ns/1ps
module hc595_chain_driver #(
  parameter int NUM_CHIPS    = 2,
  parameter int DIV          = 4,
  parameter int LSB_FIRST    = 0,
  parameter int AUTO_REFRESH = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_CHIPS-1:0] data,
  input  logic                   load_valid,
  output logic                   load_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   SH_CP,
  output logic                   ST_CP,
  output logic                   DS,
  output logic                   oe_n
);
  localparam int W  = 8 * NUM_CHIPS;
  localparam int DW = $clog2(DIV) + 1;
  localparam int BW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  state_e         state_q;
  logic [W-1:0]   hold_q, shift_q;
  logic           held_q;
  logic [DW-1:0]  div_q;
  logic [BW-1:0]  bit_q;
  logic           phase_q;
  logic           sh_q, st_q, ds_q, done_q, oen_q;

  logic           tick, start_d, first_bit_d, next_bit_d;
  logic [W-1:0]   src_d, shifted_d;
  logic [DW-1:0]  div_d;

  // A fresh load always wins over an auto-refresh of the held frame.
  always_comb begin
    tick        = (div_q == DW'(DIV - 1));
    div_d       = tick ? '0 : div_q + DW'(1);
    start_d     = load_valid || ((AUTO_REFRESH != 0) && held_q);
    src_d       = load_valid ? data : hold_q;
    first_bit_d = (LSB_FIRST != 0) ? src_d[0] : src_d[W-1];
    next_bit_d  = (LSB_FIRST != 0) ? shift_q[1] : shift_q[W-2];
    shifted_d   = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      held_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      sh_q    <= 1'b0;
      st_q    <= 1'b0;
      ds_q    <= 1'b0;
      done_q  <= 1'b0;
      oen_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            hold_q  <= src_d;
            shift_q <= src_d;
            held_q  <= 1'b1;
            bit_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            ds_q    <= first_bit_d;
            sh_q    <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          div_q <= div_d;
          if (tick) begin
            if (!phase_q) begin
              sh_q    <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              sh_q    <= 1'b0;
              phase_q <= 1'b0;
              if (bit_q == BW'(W - 1)) begin
                state_q <= LATCH;
              end else begin
                bit_q   <= bit_q + BW'(1);
                shift_q <= shifted_d;
                ds_q    <= next_bit_d;
              end
            end
          end
        end
        LATCH: begin
          div_q <= div_d;
          if (tick) begin
            if (!phase_q) begin
              st_q    <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              // Outputs are enabled only once a complete frame has been latched.
              st_q    <= 1'b0;
              phase_q <= 1'b0;
              done_q  <= 1'b1;
              oen_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign SH_CP      = sh_q;
  assign ST_CP      = st_q;
  assign DS         = ds_q;
  assign oe_n       = oen_q;
endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench: four driver configurations share one clock; a selectable monitor
// measures bit stream and strobe timing relative to the acceptance edge.
`timescale 1ns/1ps
module tb_hc595_chain_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] dA = '0, dB = '0;
  logic [7:0]  dC = '0;
  logic [23:0] dD = '0;
  logic vA = 1'b0, vB = 1'b0, vC = 1'b0, vD = 1'b0;
  logic [3:0] rdy, bsy, dn, sh, st, ds, oen;

  int checks = 0, errors = 0;
  int sel = 0;
  logic [31:0] bits;
  int rises, first_rise, st_first, st_last, done_cyc, done_n, oen_fall;
  logic rdy0, rdy1, rdy_end;

  always #5 clk = ~clk;

  hc595_chain_driver #(.NUM_CHIPS(2), .DIV(4), .LSB_FIRST(0), .AUTO_REFRESH(0)) uA (
    .clk(clk), .rst(rst), .data(dA), .load_valid(vA), .load_ready(rdy[0]), .busy(bsy[0]),
    .done(dn[0]), .SH_CP(sh[0]), .ST_CP(st[0]), .DS(ds[0]), .oe_n(oen[0]));
  hc595_chain_driver #(.NUM_CHIPS(2), .DIV(4), .LSB_FIRST(1), .AUTO_REFRESH(0)) uB (
    .clk(clk), .rst(rst), .data(dB), .load_valid(vB), .load_ready(rdy[1]), .busy(bsy[1]),
    .done(dn[1]), .SH_CP(sh[1]), .ST_CP(st[1]), .DS(ds[1]), .oe_n(oen[1]));
  hc595_chain_driver #(.NUM_CHIPS(1), .DIV(1), .LSB_FIRST(0), .AUTO_REFRESH(1)) uC (
    .clk(clk), .rst(rst), .data(dC), .load_valid(vC), .load_ready(rdy[2]), .busy(bsy[2]),
    .done(dn[2]), .SH_CP(sh[2]), .ST_CP(st[2]), .DS(ds[2]), .oe_n(oen[2]));
  hc595_chain_driver #(.NUM_CHIPS(3), .DIV(2), .LSB_FIRST(0), .AUTO_REFRESH(0)) uD (
    .clk(clk), .rst(rst), .data(dD), .load_valid(vD), .load_ready(rdy[3]), .busy(bsy[3]),
    .done(dn[3]), .SH_CP(sh[3]), .ST_CP(st[3]), .DS(ds[3]), .oe_n(oen[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge 0 is the acceptance edge; cycle c is sampled on the negedge after edge c.
  task automatic measure(input int n, input bit hold_req);
    logic p, po;
    bits = '0; rises = 0; first_rise = -1; st_first = -1; st_last = -1;
    done_cyc = -1; done_n = 0; oen_fall = -1;
    @(posedge clk); @(negedge clk);
    if (hold_req) dA = 16'hFFFF;
    else begin vA = 1'b0; vB = 1'b0; vC = 1'b0; vD = 1'b0; end
    rdy0 = rdy[sel]; p = sh[sel]; po = oen[sel]; rdy1 = 1'bx;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); @(negedge clk);
      if (sh[sel] && !p) begin
        bits = {bits[30:0], ds[sel]};
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      p = sh[sel];
      if (st[sel]) begin
        if (st_first < 0) st_first = c;
        st_last = c;
      end
      if (dn[sel]) begin
        if (done_cyc < 0) done_cyc = c;
        done_n++;
      end
      if (po && !oen[sel]) oen_fall = c;
      po = oen[sel];
      if (c == 1) rdy1 = rdy[sel];
      rdy_end = rdy[sel];
    end
  endtask

  initial begin
    int r, cnt_sh, cnt_st;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_SH_CP", 32'(sh[0]), 0);
    chk("rst_ST_CP", 32'(st[0]), 0);
    chk("rst_DS", 32'(ds[0]), 0);
    chk("rst_oe_n", 32'(oen[0]), 1);
    chk("rst_done", 32'(dn[0]), 0);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_load_ready", 32'(rdy[0]), 1);
    rst = 1'b0;
    @(negedge clk);

    // MSB-first 16-bit frame, DIV=4
    sel = 0; dA = 16'hA5C3; vA = 1'b1;
    measure(136, 1'b0);
    chk("A_busy_after_accept", 32'(rdy0), 0);
    chk("A_ready_c1", 32'(rdy1), 0);
    chk("A_bits", bits, 32'h0000A5C3);
    chk("A_rises", rises, 16);
    chk("A_first_rise", first_rise, 4);
    chk("A_st_first", st_first, 132);
    chk("A_st_last", st_last, 135);
    chk("A_done_cyc", done_cyc, 136);
    chk("A_done_n", done_n, 1);
    chk("A_oe_fall", oen_fall, 136);
    chk("A_ready_after_done", 32'(rdy_end), 1);

    // LSB-first
    sel = 1; dB = 16'hA5C3; vB = 1'b1;
    measure(136, 1'b0);
    chk("B_bits", bits, 32'h0000C3A5);
    chk("B_done_cyc", done_cyc, 136);

    // Request held through the frame with changing data
    sel = 0; dA = 16'h1234; vA = 1'b1;
    measure(136, 1'b1);
    chk("M1_ready_c1", 32'(rdy1), 0);
    chk("M1_bits", bits, 32'h00001234);
    chk("M1_done_cyc", done_cyc, 136);
    measure(136, 1'b0);
    chk("M2_accept_next_cycle", 32'(rdy0), 0);
    chk("M2_first_rise", first_rise, 4);
    chk("M2_bits", bits, 32'h0000FFFF);
    chk("M2_done_cyc", done_cyc, 136);

    // Auto-refresh, 8 bits, DIV=1: 19-cycle period
    sel = 2; dC = 8'h81; vC = 1'b1;
    measure(18, 1'b0);
    chk("C1_bits", bits, 32'h81);
    chk("C1_first_rise", first_rise, 1);
    chk("C1_st_first", st_first, 17);
    chk("C1_done_cyc", done_cyc, 18);
    for (int f = 0; f < 2; f++) begin
      measure(18, 1'b0);
      chk("CR_restarted", 32'(rdy0), 0);
      chk("CR_bits", bits, 32'h81);
      chk("CR_rises", rises, 8);
      chk("CR_done_cyc", done_cyc, 18);
    end

    // Reset at the 5th SH_CP rise of a frame
    sel = 0; dA = 16'hFFFF; vA = 1'b1;
    @(posedge clk); @(negedge clk);
    vA = 1'b0;
    r = 0;
    begin
      logic p;
      p = sh[0];
      for (int c = 1; c <= 60 && r < 5; c++) begin
        @(posedge clk); @(negedge clk);
        if (sh[0] && !p) r++;
        p = sh[0];
      end
    end
    chk("R_reached_5th_rise", r, 5);
    rst = 1'b1;
    #1;
    chk("R_SH_CP", 32'(sh[0]), 0);
    chk("R_ST_CP", 32'(st[0]), 0);
    chk("R_DS", 32'(ds[0]), 0);
    chk("R_oe_n", 32'(oen[0]), 1);
    chk("R_busy", 32'(bsy[0]), 0);
    chk("R_C_SH_CP", 32'(sh[2]), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt_sh = 0; cnt_st = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sh[2]) cnt_sh++;
      if (st[0] || st[2]) cnt_st++;
    end
    chk("R_auto_idle_sh", cnt_sh, 0);
    chk("R_no_st_pulse", cnt_st, 0);

    // 24-bit chain, DIV=2
    sel = 3; dD = 24'h5AF03C; vD = 1'b1;
    measure(100, 1'b0);
    chk("D_bits", bits, 32'h005AF03C);
    chk("D_rises", rises, 24);
    chk("D_st_first", st_first, 98);
    chk("D_st_last", st_last, 99);
    chk("D_done_cyc", done_cyc, 100);
    chk("D_oe_fall", oen_fall, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
